rst_req_sched: RTL and testbench

- Reset-request scheduler in the clk_osc domain, upstream of the reset generation unit.
- Collects single-cycle soft-reset requests (software CPU, debug CPU, software system) and a PMU power-off level request.
- Arbitrates them and drives the reset generator's cpu_soft_rst[1:0] code and pmu_rst_ctl with the required pulse width and guard spacing.
- Reports busy, completion and sticky cause status to the register bank.

---
 rtl/rst_req_sched_if.sv | 23 ++
 rtl/rst_req_sched.sv | 121 ++++++++++++
 tb/tb_rst_req_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rst_req_sched_if.sv
// rst_req_sched_if: reset request inputs and reset-generator/status outputs of the scheduler.
interface rst_req_sched_if;
    logic       sw_cpu_rst_req;
    logic       dbg_cpu_rst_req;
    logic       sw_sys_rst_req;
    logic       pmu_off_req;
    logic       cause_clr;
    logic [1:0] cpu_soft_rst;
    logic       pmu_rst_ctl;
    logic       rst_busy;
    logic       rst_done;
    logic [3:0] rst_cause;

    modport master (
        output sw_cpu_rst_req, dbg_cpu_rst_req, sw_sys_rst_req, pmu_off_req, cause_clr,
        input  cpu_soft_rst, pmu_rst_ctl, rst_busy, rst_done, rst_cause
    );

    modport slave (
        input  sw_cpu_rst_req, dbg_cpu_rst_req, sw_sys_rst_req, pmu_off_req, cause_clr,
        output cpu_soft_rst, pmu_rst_ctl, rst_busy, rst_done, rst_cause
    );
endinterface

// File: rtl/rst_req_sched.sv
// rst_req_sched: arbitrates soft-reset and PMU power-off requests into timed
// cpu_soft_rst / pmu_rst_ctl sequences with hold, guard and minimum-off spacing.
module rst_req_sched #(
    parameter int HOLD_CYC    = 4,
    parameter int GUARD_CYC   = 40,
    parameter int PMU_MIN_CYC = 16
) (
    input  logic           clk_osc,
    input  logic           reset_osc,
    rst_req_sched_if.slave bus
);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYC - 1);
    localparam logic [7:0] PMU_LAST   = 8'(PMU_MIN_CYC - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, GUARD, PMU_OFF} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_sw_q, pend_sw_d, pend_dbg_q, pend_dbg_d, pend_sys_q, pend_sys_d;
    logic [1:0] code_q, code_d;
    logic       pmu_ctl_q, pmu_ctl_d, busy_q, busy_d, done_q, done_d;
    logic [3:0] cause_q, cause_d, grant_cause;
    logic       sw, dbg, sys, accept;

    always_comb begin
        accept      = state_q != PMU_OFF;
        sw          = pend_sw_q | (bus.sw_cpu_rst_req & accept);
        dbg         = pend_dbg_q | (bus.dbg_cpu_rst_req & accept);
        sys         = pend_sys_q | (bus.sw_sys_rst_req & accept);
        state_d     = state_q;
        cnt_d       = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
        pend_sw_d   = sw;
        pend_dbg_d  = dbg;
        pend_sys_d  = sys;
        code_d      = code_q;
        pmu_ctl_d   = pmu_ctl_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        grant_cause = 4'b0000;
        case (state_q)
            IDLE: begin
                // Grants consume the current-cycle pulses together with the pending bits
                if (bus.pmu_off_req) begin
                    state_d     = PMU_OFF;
                    cnt_d       = 8'd0;
                    pmu_ctl_d   = 1'b0;
                    busy_d      = 1'b1;
                    grant_cause = 4'b1000;
                    pend_sw_d   = 1'b0;
                    pend_dbg_d  = 1'b0;
                    pend_sys_d  = 1'b0;
                end else if (sys || sw || dbg) begin
                    state_d     = ASSERT;
                    cnt_d       = 8'd0;
                    code_d      = sys ? 2'b10 : 2'b01;
                    busy_d      = 1'b1;
                    grant_cause = {1'b0, sys, dbg, sw};
                    pend_sw_d   = 1'b0;
                    pend_dbg_d  = 1'b0;
                    pend_sys_d  = 1'b0;
                end
            end
            ASSERT: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GUARD;
                    cnt_d   = 8'd0;
                    code_d  = 2'b00;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            PMU_OFF: begin
                if (!bus.pmu_off_req && cnt_q >= PMU_LAST) begin
                    state_d   = GUARD;
                    cnt_d     = 8'd0;
                    pmu_ctl_d = 1'b1;
                end
            end
        endcase
        cause_d = (bus.cause_clr ? 4'b0000 : cause_q) | grant_cause;
    end

    always_ff @(posedge clk_osc) begin
        if (reset_osc) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            pend_sw_q  <= 1'b0;
            pend_dbg_q <= 1'b0;
            pend_sys_q <= 1'b0;
            code_q     <= 2'b00;
            pmu_ctl_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cause_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_sw_q  <= pend_sw_d;
            pend_dbg_q <= pend_dbg_d;
            pend_sys_q <= pend_sys_d;
            code_q     <= code_d;
            pmu_ctl_q  <= pmu_ctl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cause_q    <= cause_d;
        end
    end

    assign bus.cpu_soft_rst = code_q;
    assign bus.pmu_rst_ctl  = pmu_ctl_q;
    assign bus.rst_busy     = busy_q;
    assign bus.rst_done     = done_q;
    assign bus.rst_cause    = cause_q;
endmodule

// File: tb/tb_rst_req_sched.sv
// tb_rst_req_sched: directed and random stimulus against a timestamp-based model of
// the reset sequences (each grant schedules its hold, busy, done and next-arbitration cycles).
module tb_rst_req_sched;
    localparam int HOLD    = 4;
    localparam int GUARD   = 40;
    localparam int PMU_MIN = 16;
    localparam int INF     = 1 << 30;

    logic clk_osc   = 1'b0;
    logic reset_osc = 1'b1;
    rst_req_sched_if bus();

    rst_req_sched #(.HOLD_CYC(HOLD), .GUARD_CYC(GUARD), .PMU_MIN_CYC(PMU_MIN)) dut (
        .clk_osc(clk_osc), .reset_osc(reset_osc), .bus(bus)
    );

    always #31 clk_osc = ~clk_osc;

    int vectors = 0, miscompares = 0, t = 0;
    bit armed = 0;
    int arb_at, code_lo, code_hi, busy_lo, busy_hi, done_at, pmu_lo, pmu_hi;
    logic [1:0] code_val;
    logic [2:0] pend;
    logic [3:0] cause;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: got %b expected %b", tag, t, got, exp);
        end
    endtask

    task automatic m_reset();
        arb_at = t + 1; code_lo = 0; code_hi = -1; busy_lo = 0; busy_hi = -1;
        done_at = -1; pmu_lo = INF; pmu_hi = -1; code_val = 2'b00; pend = 3'b000; cause = 4'b0000;
    endtask

    task automatic start_seq(input logic [1:0] v);
        code_val = v; code_lo = t + 1; code_hi = t + HOLD;
        busy_lo = t + 1; busy_hi = t + HOLD + GUARD; done_at = busy_hi + 1; arb_at = done_at;
    endtask

    task automatic cyc(input logic sw, input logic dbg, input logic sys, input logic pmu,
                       input logic clr, input logic rst);
        logic [3:0] g;
        logic [1:0] e_code;
        logic in_pmu;
        @(negedge clk_osc);
        if (armed) begin
            in_pmu = t >= pmu_lo && t <= pmu_hi;
            e_code = (t >= code_lo && t <= code_hi) ? code_val : 2'b00;
            chk("cpu_soft_rst", {2'b00, bus.cpu_soft_rst}, {2'b00, e_code});
            chk("pmu_rst_ctl", {3'b000, bus.pmu_rst_ctl}, {3'b000, !in_pmu});
            chk("rst_busy", {3'b000, bus.rst_busy}, {3'b000, t >= busy_lo && t <= busy_hi});
            chk("rst_done", {3'b000, bus.rst_done}, {3'b000, t == done_at});
            chk("rst_cause", bus.rst_cause, cause);
            chk("code_legal", {3'b000, bus.cpu_soft_rst != 2'b11 &&
                (bus.pmu_rst_ctl || bus.cpu_soft_rst == 2'b00)}, 4'b0001);
        end
        bus.sw_cpu_rst_req = sw; bus.dbg_cpu_rst_req = dbg; bus.sw_sys_rst_req = sys;
        bus.pmu_off_req = pmu; bus.cause_clr = clr; reset_osc = rst;
        g = 4'b0000;
        if (rst) begin
            m_reset();
            armed = 1;
        end else if (t >= pmu_lo && t <= pmu_hi) begin
            if (!pmu && t >= pmu_lo + PMU_MIN - 1) begin
                pmu_hi = t; busy_hi = t + GUARD; done_at = t + GUARD + 1; arb_at = done_at;
            end
        end else begin
            pend = pend | {sys, dbg, sw};
            if (t >= arb_at) begin
                if (pmu) begin
                    pmu_lo = t + 1; pmu_hi = INF; busy_lo = t + 1; busy_hi = INF; arb_at = INF;
                    g = 4'b1000; pend = 3'b000;
                end else if (pend != 3'b000) begin
                    start_seq(pend[2] ? 2'b10 : 2'b01);
                    g = {1'b0, pend}; pend = 3'b000;
                end
            end
        end
        if (!rst) cause = (clr ? 4'b0000 : cause) | g;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic sw, dbg, sys, clr, rst, pmu_lvl;
        bus.sw_cpu_rst_req = 0; bus.dbg_cpu_rst_req = 0; bus.sw_sys_rst_req = 0;
        bus.pmu_off_req = 0; bus.cause_clr = 0;
        do_reset();
        idle(20);
        chk("reset_idle_code", {2'b00, bus.cpu_soft_rst}, 4'b0000);
        chk("reset_idle_pmu", {3'b000, bus.pmu_rst_ctl}, 4'b0001);

        cyc(1, 0, 0, 0, 0, 0);
        idle(60);
        chk("sw_cause", bus.rst_cause, 4'b0001);

        do_reset();
        cyc(0, 1, 1, 0, 0, 0);
        idle(60);
        chk("sys_dbg_cause", bus.rst_cause, 4'b0110);
        chk("sys_dbg_no_second", {3'b000, bus.rst_busy}, 4'b0000);

        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        idle(9);
        cyc(0, 0, 1, 0, 0, 0);
        idle(100);
        chk("dbg_then_sys_cause", bus.rst_cause, 4'b0110);

        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 0, 0);
        idle(70);
        chk("pmu_cause", bus.rst_cause, 4'b1000);

        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1);
        idle(10);
        chk("abort_busy", {3'b000, bus.rst_busy}, 4'b0000);

        do_reset();
        cyc(0, 0, 1, 0, 0, 0);
        idle(50);
        chk("pre_clr_cause", bus.rst_cause, 4'b0100);
        cyc(1, 0, 0, 0, 1, 0);
        idle(1);
        chk("clr_grant_cause", bus.rst_cause, 4'b0001);
        idle(50);

        pmu_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            sw  = $urandom_range(0, 24) == 0;
            dbg = $urandom_range(0, 24) == 0;
            sys = $urandom_range(0, 40) == 0;
            clr = $urandom_range(0, 60) == 0;
            rst = $urandom_range(0, 700) == 0;
            if ($urandom_range(0, (pmu_lvl ? 10 : 150)) == 0) pmu_lvl = !pmu_lvl;
            cyc(sw, dbg, sys, pmu_lvl, clr, rst);
        end
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
